// File: rtl/output_port_arbiter_pkg.sv
// Shared constants for the output-port arbiter: packet geometry defaults and field offsets.
package output_port_arbiter_pkg;

    localparam int DEF_PAYLOAD_BITS  = 64;
    localparam int DEF_NUM_ADDR_BITS = 23;
    localparam int DEF_NUM_PORT_BITS = 4;
    localparam int DEF_NUM_LEAF_BITS = 5;
    localparam int DEF_PACKET_BITS   = 1 + DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS
                                       + DEF_NUM_ADDR_BITS + DEF_PAYLOAD_BITS;
    localparam int DEF_NUM_OUT_PORTS = 7;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + DEF_PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + DEF_NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + DEF_NUM_PORT_BITS;
    localparam int PKT_VLD_BIT = LEAF_LSB + DEF_NUM_LEAF_BITS;

    typedef struct packed {
        logic                         vld;
        logic [DEF_NUM_LEAF_BITS-1:0] leaf;
        logic [DEF_NUM_PORT_BITS-1:0] port;
        logic [DEF_NUM_ADDR_BITS-1:0] addr;
        logic [DEF_PAYLOAD_BITS-1:0]  payload;
    } pkt_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// FIFO-head and BFT-handshake bundle; master is the arbiter, slave is the FIFO/switch side.
interface output_port_arbiter_if
    import output_port_arbiter_pkg::*;
#(
    parameter int PACKET_BITS   = DEF_PACKET_BITS,
    parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS
);
    logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out;
    logic [NUM_OUT_PORTS-1:0]             empty;
    logic [NUM_OUT_PORTS-1:0]             rd_en_sel;
    logic [PACKET_BITS-1:0]               dout_leaf_interface2bft;
    logic                                 vld_interface2bft;
    logic                                 rdy_bft2interface;

    modport master (
        input  internal_out, empty, rdy_bft2interface,
        output rd_en_sel, dout_leaf_interface2bft, vld_interface2bft
    );

    modport slave (
        output internal_out, empty, rdy_bft2interface,
        input  rd_en_sel, dout_leaf_interface2bft, vld_interface2bft
    );
endinterface

// File: rtl/output_port_arbiter_rr_grant_sel.sv
// Round-robin search: first requester strictly after last_grant, wrapping at N-1 back to 0.
module rr_grant_sel
    import output_port_arbiter_pkg::*;
#(
    parameter  int N  = DEF_NUM_OUT_PORTS,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic          found_s;
    logic [IW-1:0] idx_s;

    // Walk offsets 1..N from last_grant so last_grant itself is checked last.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        any_req   = |req;
        for (int off = 1; off <= N; off++) begin
            idx_s = IW'((int'(last_grant) + off) % N);
            if (!found_s && req[idx_s]) begin
                found_s         = 1'b1;
                grant_oh[idx_s] = 1'b1;
                grant_idx       = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin drain of NUM_OUT_PORTS FWFT FIFOs into one registered BFT output.
// Optional transfer counter port pkt_cnt is built only with OUT_ARB_PKT_CNT_EN defined.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int PACKET_BITS   = DEF_PACKET_BITS,
    parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS
) (
    input  logic                  clk_bft,
    input  logic                  reset,
    output_port_arbiter_if.master bus
`ifdef OUT_ARB_PKT_CNT_EN
    ,
    output logic [31:0]           pkt_cnt
`endif
);

    localparam int IW = idx_width(NUM_OUT_PORTS);

    logic [NUM_OUT_PORTS-1:0] req_s;
    logic [NUM_OUT_PORTS-1:0] grant_oh_s;
    logic [IW-1:0]            grant_idx_s;
    logic                     any_req_s;
    logic                     load_s;
    logic                     xfer_s;
    logic [PACKET_BITS-1:0]   head_s;
    logic [PACKET_BITS-1:0]   dout_d, dout_q;
    logic                     vld_d, vld_q;
    logic [IW-1:0]            last_grant_d, last_grant_q;

    assign req_s = ~bus.empty;

    rr_grant_sel #(.N(NUM_OUT_PORTS)) u_rr_grant_sel (
        .req        (req_s),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh_s),
        .grant_idx  (grant_idx_s),
        .any_req    (any_req_s)
    );

    // AND-OR mux of the granted head packet; grant is one-hot so at most one term survives.
    always_comb begin
        head_s = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            head_s = head_s | ({PACKET_BITS{grant_oh_s[i]}}
                               & bus.internal_out[i*PACKET_BITS +: PACKET_BITS]);
        end
    end

    // Load when the output register is free or draining; pop is gated off during reset.
    always_comb begin
        xfer_s = vld_q & bus.rdy_bft2interface;
        load_s = (~vld_q | bus.rdy_bft2interface) & any_req_s;
        if (load_s) begin
            dout_d       = head_s;
            vld_d        = 1'b1;
            last_grant_d = grant_idx_s;
        end else begin
            dout_d       = dout_q;
            vld_d        = xfer_s ? 1'b0 : vld_q;
            last_grant_d = last_grant_q;
        end
        if (load_s && reset) begin
            bus.rd_en_sel = grant_oh_s;
        end else begin
            bus.rd_en_sel = '0;
        end
    end

    // Output register and round-robin pointer; pointer restarts so port 0 wins first.
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            dout_q       <= '0;
            vld_q        <= 1'b0;
            last_grant_q <= IW'(NUM_OUT_PORTS - 1);
        end else begin
            dout_q       <= dout_d;
            vld_q        <= vld_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.dout_leaf_interface2bft = dout_q;
    assign bus.vld_interface2bft       = vld_q;

`ifdef OUT_ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt_d, pkt_cnt_q;

    // Saturating count of accepted transfers.
    always_comb begin
        if (xfer_s && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= 32'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed self-checking bench for output_port_arbiter with a per-port FWFT FIFO model.
module tb_output_port_arbiter;

    localparam int PB = 97;
    localparam int NP = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_arbiter_if #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP)) bus ();

    int            n_cmp = 0;
    int            n_err = 0;
    int            seq[NP];
    logic [NP-1:0] rd_cap;
    logic [PB-1:0] exp_pkt;
    logic [NP-1:0] exp_rd;

`ifdef OUT_ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt;
    output_port_arbiter #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP)) dut (
        .clk_bft (clk),
        .reset   (rst_n),
        .bus     (bus),
        .pkt_cnt (pkt_cnt)
    );
`else
    output_port_arbiter #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP)) dut (
        .clk_bft (clk),
        .reset   (rst_n),
        .bus     (bus)
    );
`endif

    function automatic logic [PB-1:0] make_pkt(input int p, input int s);
        return {1'b1, 32'(p), 64'(s)};
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < NP; i++) bus.internal_out[i*PB +: PB] = make_pkt(i, seq[i]);
    endtask

    // Capture pops before the edge, then advance the FIFO model just after it.
    task automatic tick();
        rd_cap = bus.rd_en_sel;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) if (rd_cap[i]) seq[i] = seq[i] + 1;
        drive_heads();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.empty = '1;
        bus.rdy_bft2interface = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_rd(input string nm, input logic [NP-1:0] want);
        n_cmp++;
        if (bus.rd_en_sel !== want) begin
            n_err++;
            $display("FAIL %s: rd_en_sel got %b want %b", nm, bus.rd_en_sel, want);
        end
    endtask

    task automatic test_reset();
        bus.empty = '1;
        bus.rdy_bft2interface = 1'b0;
        drive_heads();
        #2;
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b0) begin
            n_err++; $display("FAIL reset_vld: got %b want 0", bus.vld_interface2bft);
        end
        n_cmp++;
        if (bus.dout_leaf_interface2bft !== '0) begin
            n_err++; $display("FAIL reset_dout: got %h want 0", bus.dout_leaf_interface2bft);
        end
        bus.empty = '0;
        #1;
        chk_rd("reset_rd_gated", 7'b0000000);
        tick();
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b0) begin
            n_err++; $display("FAIL reset_hold_vld: got %b want 0", bus.vld_interface2bft);
        end
        bus.empty = '1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_first_grant();
        bus.empty = 7'b1111110;
        bus.rdy_bft2interface = 1'b1;
        #1;
        chk_rd("first_rd", 7'b0000001);
        exp_pkt = make_pkt(0, seq[0]);
        tick();
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b1) begin
            n_err++; $display("FAIL first_vld: got %b want 1", bus.vld_interface2bft);
        end
        n_cmp++;
        if (bus.dout_leaf_interface2bft !== exp_pkt) begin
            n_err++; $display("FAIL first_dout: got %h want %h", bus.dout_leaf_interface2bft, exp_pkt);
        end
        bus.empty = '1;
        #1;
        chk_rd("drain_rd", 7'b0000000);
        tick();
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b0) begin
            n_err++; $display("FAIL drain_vld: got %b want 0", bus.vld_interface2bft);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.empty = '0;
        bus.rdy_bft2interface = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            exp_rd = 7'b0000001 << (c % NP);
            chk_rd("rr_rd", exp_rd);
            exp_pkt = make_pkt(c % NP, seq[c % NP]);
            tick();
            n_cmp++;
            if (bus.vld_interface2bft !== 1'b1 || bus.dout_leaf_interface2bft !== exp_pkt) begin
                n_err++;
                $display("FAIL rr_dout c=%0d: got vld=%b %h want vld=1 %h", c,
                         bus.vld_interface2bft, bus.dout_leaf_interface2bft, exp_pkt);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.rdy_bft2interface = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_rd("bp_rd", 7'b0000000);
            tick();
            n_cmp++;
            if (bus.vld_interface2bft !== 1'b1 || bus.dout_leaf_interface2bft !== exp_pkt) begin
                n_err++;
                $display("FAIL bp_hold k=%0d: got vld=%b %h want vld=1 %h", k,
                         bus.vld_interface2bft, bus.dout_leaf_interface2bft, exp_pkt);
            end
        end
        bus.rdy_bft2interface = 1'b1;
        #1;
        chk_rd("bp_release_rd", 7'b0000001);
        exp_pkt = make_pkt(0, seq[0]);
        tick();
        n_cmp++;
        if (bus.dout_leaf_interface2bft !== exp_pkt) begin
            n_err++; $display("FAIL bp_release_dout: got %h want %h", bus.dout_leaf_interface2bft, exp_pkt);
        end
        bus.empty = '1;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.empty = 7'b1110111;
        bus.rdy_bft2interface = 1'b1;
        #1;
        chk_rd("wrap_rd3", 7'b0001000);
        exp_pkt = make_pkt(3, seq[3]);
        tick();
        n_cmp++;
        if (bus.dout_leaf_interface2bft !== exp_pkt) begin
            n_err++; $display("FAIL wrap_dout3: got %h want %h", bus.dout_leaf_interface2bft, exp_pkt);
        end
        bus.empty = 7'b1111011;
        #1;
        chk_rd("wrap_rd2", 7'b0000100);
        exp_pkt = make_pkt(2, seq[2]);
        tick();
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b1 || bus.dout_leaf_interface2bft !== exp_pkt) begin
            n_err++; $display("FAIL wrap_dout2: got vld=%b %h want vld=1 %h",
                              bus.vld_interface2bft, bus.dout_leaf_interface2bft, exp_pkt);
        end
        bus.empty = '1;
        tick();
    endtask

    task automatic test_reset_midop();
        bus.empty = 7'b1111110;
        bus.rdy_bft2interface = 1'b0;
        #1;
        tick();
        bus.empty = '1;
        #1;
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b1) begin
            n_err++; $display("FAIL midop_held_vld: got %b want 1", bus.vld_interface2bft);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b0 || bus.dout_leaf_interface2bft !== '0) begin
            n_err++; $display("FAIL midop_async_clear: got vld=%b %h want vld=0 0",
                              bus.vld_interface2bft, bus.dout_leaf_interface2bft);
        end
        tick();
        tick();
        rst_n = 1'b1;
        bus.rdy_bft2interface = 1'b1;
        #1;
        tick();
        tick();
        n_cmp++;
        if (bus.vld_interface2bft !== 1'b0) begin
            n_err++; $display("FAIL midop_no_replay: vld got %b want 0", bus.vld_interface2bft);
        end
        bus.empty = 7'b1111110;
        #1;
        chk_rd("midop_next_rd", 7'b0000001);
        exp_pkt = make_pkt(0, seq[0]);
        tick();
        n_cmp++;
        if (bus.dout_leaf_interface2bft !== exp_pkt) begin
            n_err++; $display("FAIL midop_next_dout: got %h want %h", bus.dout_leaf_interface2bft, exp_pkt);
        end
        bus.empty = '1;
        tick();
    endtask

`ifdef OUT_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        do_reset();
        n_cmp++;
        if (pkt_cnt !== 32'd0) begin
            n_err++; $display("FAIL cnt_reset: got %0d want 0", pkt_cnt);
        end
        bus.empty = '0;
        bus.rdy_bft2interface = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) tick();
        bus.empty = '1;
        tick();
        n_cmp++;
        if (pkt_cnt !== 32'd10) begin
            n_err++; $display("FAIL cnt_ten: got %0d want 10", pkt_cnt);
        end
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        bus.empty = 7'b1111110;
        #1;
        tick();
        bus.empty = '1;
        tick();
        n_cmp++;
        if (pkt_cnt !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL cnt_saturate: got %h want ffffffff", pkt_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NP; i++) seq[i] = 0;
        rd_cap = '0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_midop();
`ifdef OUT_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
